mpu_store: RTL and testbench
============================

Name: mpu_store

Overview:
- Reverse path of the matrix load unit: reads one matrix from the MPU register file and streams its elements, row-major, to memory/file with a valid/ready handshake.
- Takes a snapshot of the register contents at start, so the register file may be rewritten while the stream is still running.
- Sits between mpu_register_file (store-address/read side) and the memory/output interface. Started by the MPU controller on a STORE operation.

Parameters:
- FP, 32, element width in bits (IEEE-754 single).
- M, 4, maximum matrix rows.
- N, 4, maximum matrix columns.
- MBITS, $clog2(M), row-index width; size fields are MBITS+1 bits.
- NBITS, $clog2(N), column-index width; size fields are NBITS+1 bits.
- MATRIX_REG_SIZE, 3, register-file address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; sampled only in ST_IDLE.
- store_addr  in  MATRIX_REG_SIZE  register to read.
- reg_store_addr  out  MATRIX_REG_SIZE  address to the register file.
- matrix_in  in  FP*M*N  register-file read data; element (i,j) at [(i*N+j)*FP +: FP].
- reg_m  in  MBITS+1  stored row count of the addressed register.
- reg_n  in  NBITS+1  stored column count of the addressed register.
- element_out  out  FP  streamed element.
- valid  out  1  element_out is valid.
- ready  in  1  downstream accepts the element.
- matrix_m_size  out  MBITS+1  captured row count.
- matrix_n_size  out  NBITS+1  captured column count.
- busy  out  1  high in every state except ST_IDLE.
- ack  out  1  one-cycle pulse when the store completes.
- error  out  1  one-cycle pulse when captured dimensions are illegal.

Behaviour:
- Reset (async, immediate): state ST_IDLE; all outputs 0; row/col counters 0. Snapshot buffer contents are don't-care. Reset mid-stream aborts the transfer with no ack.
- Register-file read is combinational from reg_store_addr.
- ST_IDLE:
  - If en=1 at edge k: reg_store_addr<=store_addr; go to ST_FETCH.
  - Otherwise stay in ST_IDLE.
- ST_FETCH (1 cycle): at edge k+1, capture matrix_in, reg_m and reg_n into the snapshot and into matrix_m_size/matrix_n_size.
  - Illegal if m==0, n==0, m>M or n>N: go to ST_DONE with error=1. ack and valid stay 0.
  - Otherwise go to ST_STREAM with row=col=0.
- ST_STREAM:
  - valid=1; element_out=snapshot[row][col].
  - Handshake is valid&&ready at a rising edge. On a handshake: col++; if col==n-1 then col=0, row++.
  - While ready=0: valid and element_out are held stable. valid never drops mid-stream.
  - On the handshake of element (m-1,n-1): valid<=0; go to ST_DONE with ack=1.
- ST_DONE (1 cycle): ack or error is high for this cycle only; then go to ST_IDLE.
  - ack and error are never high together.
- Latency with ready tied high: first valid in cycle k+2; ack in cycle k+2+m*n; busy falls at edge k+3+m*n.
- en while busy is ignored. No queuing: the request is lost.
- matrix_m_size/matrix_n_size hold the last captured value until the next capture.
- Non-square and partial sizes (e.g. 2x3 in a 4x4 register) stream exactly m*n elements. Only indices inside m×n are read.

Decomposition:
- mpu_pkg: typedef enum store_state_t {ST_IDLE, ST_FETCH, ST_STREAM, ST_DONE}.
- global_defs: FP, M, N, MBITS, NBITS, MATRIX_REG_SIZE as shared constants.
- Sub-module mpu_matrix_index: row/column counter.
  - Inputs: clear, advance, m, n.
  - Outputs: row, col, last (asserted at (m-1,n-1)).
  - Reusable by mpu_load.

Test Plan:
- 2x2 register 0 holding 3f800000, 424951ec, c0200000, 3e000000; en pulse at cycle 0, ready=1 -> valid in cycles 2–5 with exactly that order; ack pulse in cycle 6; matrix_m_size=2, matrix_n_size=2; error=0.
- Same 2x2 transfer with ready=0 for cycles 3–5 -> element_out=424951ec and valid=1 held through cycles 3–6; ack moves to cycle 9; no duplicated or dropped element.
- reg_m=0, reg_n=2 -> error pulse in cycle 2; valid and ack never asserted; busy low from cycle 3.
- Full 4x4 with element value = index (0..15), ready toggling every cycle -> 16 elements in order 0..15; ack after the 16th handshake.
- Overwrite the register file and pulse en during cycles 3–4 of a 2x2 stream -> streamed data unchanged, the en is ignored, a single ack.
- Assert rst in cycle 3 of a 4x4 stream -> valid, busy and all outputs 0 immediately (before the next edge); a new en then restarts cleanly from element (0,0).

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared MPU constants and the store-unit state type.
// Imported by the store path and its index counter.
package mpu_pkg;

  localparam int FP              = 32;
  localparam int M               = 4;
  localparam int N               = 4;
  localparam int MBITS           = $clog2(M);
  localparam int NBITS           = $clog2(N);
  localparam int MATRIX_REG_SIZE = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_STREAM,
    ST_DONE
  } store_state_t;

endpackage

// File: rtl/mpu_matrix_index.sv
// Row-major (row, col) walker over an m x n matrix.
// Shared between the MPU load and store paths.
module mpu_matrix_index
  import mpu_pkg::*;
#(
  parameter int ROW_W = MBITS,
  parameter int COL_W = NBITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W:0]   m,
  input  logic [COL_W:0]   n,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  logic row_end;
  logic col_end;

  assign row_end = ({1'b0, row} == (m - 1'b1));
  assign col_end = ({1'b0, col} == (n - 1'b1));
  assign last    = row_end && col_end;

  // Column wraps at n-1 and carries into the row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mpu_store.sv
// Snapshots one MPU register and streams its m x n elements row-major
// over a valid/ready handshake, ending with an ack or error pulse.
module mpu_store
  import mpu_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [MATRIX_REG_SIZE-1:0] store_addr,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr,
  input  logic [FP*M*N-1:0]          matrix_in,
  input  logic [MBITS:0]             reg_m,
  input  logic [NBITS:0]             reg_n,
  output logic [FP-1:0]              element_out,
  output logic                       valid,
  input  logic                       ready,
  output logic [MBITS:0]             matrix_m_size,
  output logic [NBITS:0]             matrix_n_size,
  output logic                       busy,
  output logic                       ack,
  output logic                       error
);

  localparam int IDX_W = $clog2(M * N);
  localparam logic [MBITS:0] M_MAX = (MBITS + 1)'(M);
  localparam logic [NBITS:0] N_MAX = (NBITS + 1)'(N);

  store_state_t state, next_state;

  logic [FP*M*N-1:0] snapshot;
  logic              err_q;
  logic              illegal;
  logic              clear;
  logic              advance;
  logic              last;
  logic [MBITS-1:0]  row;
  logic [NBITS-1:0]  col;
  logic [IDX_W-1:0]  flat_idx;

  assign illegal = (reg_m == '0) || (reg_n == '0) || (reg_m > M_MAX) || (reg_n > N_MAX);

  mpu_matrix_index #(
    .ROW_W (MBITS),
    .COL_W (NBITS)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .advance (advance),
    .m       (matrix_m_size),
    .n       (matrix_n_size),
    .row     (row),
    .col     (col),
    .last    (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    clear      = 1'b0;
    advance    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (en) next_state = ST_FETCH;
      end
      ST_FETCH: begin
        clear      = 1'b1;
        next_state = illegal ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (ready) begin
          advance = 1'b1;
          if (last) next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Address latches on start; sizes and the error verdict latch in fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_store_addr <= '0;
      matrix_m_size  <= '0;
      matrix_n_size  <= '0;
      err_q          <= 1'b0;
    end else begin
      if (state == ST_IDLE && en) begin
        reg_store_addr <= store_addr;
      end
      if (state == ST_FETCH) begin
        matrix_m_size <= reg_m;
        matrix_n_size <= reg_n;
        err_q         <= illegal;
      end
    end
  end

  // Data contents need no reset; they are only observed while streaming.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH) begin
      snapshot <= matrix_in;
    end
  end

  assign flat_idx    = IDX_W'(row) * IDX_W'(N) + IDX_W'(col);
  assign valid       = (state == ST_STREAM);
  assign busy        = (state != ST_IDLE);
  assign ack         = (state == ST_DONE) && !err_q;
  assign error       = (state == ST_DONE) && err_q;
  assign element_out = valid ? snapshot[32'(flat_idx) * FP +: FP] : '0;

endmodule

// File: tb/tb_mpu_store.sv
// Randomized bench for mpu_store against a row-major queue model of the
// stored matrix and a ready-log model of handshake timing.
module tb_mpu_store;
  import mpu_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       en;
  logic [MATRIX_REG_SIZE-1:0] store_addr;
  logic [MATRIX_REG_SIZE-1:0] reg_store_addr;
  logic [FP*M*N-1:0]          matrix_in;
  logic [MBITS:0]             reg_m;
  logic [NBITS:0]             reg_n;
  logic [FP-1:0]              element_out;
  logic                       valid;
  logic                       ready;
  logic [MBITS:0]             matrix_m_size;
  logic [NBITS:0]             matrix_n_size;
  logic                       busy;
  logic                       ack;
  logic                       error;

  always #5 clk = ~clk;

  logic [FP*M*N-1:0] rf_data [8];
  logic [MBITS:0]    rf_m    [8];
  logic [NBITS:0]    rf_n    [8];

  assign matrix_in = rf_data[reg_store_addr];
  assign reg_m     = rf_m[reg_store_addr];
  assign reg_n     = rf_n[reg_store_addr];

  mpu_store dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .store_addr     (store_addr),
    .reg_store_addr (reg_store_addr),
    .matrix_in      (matrix_in),
    .reg_m          (reg_m),
    .reg_n          (reg_n),
    .element_out    (element_out),
    .valid          (valid),
    .ready          (ready),
    .matrix_m_size  (matrix_m_size),
    .matrix_n_size  (matrix_n_size),
    .busy           (busy),
    .ack            (ack),
    .error          (error)
  );

  int pass_cnt  = 0;
  int check_cnt = 0;

  logic [FP-1:0] obs_q[$];
  logic [FP-1:0] exp_q[$];
  bit            ready_log [300];
  int first_valid, ack_cycle, ack_cnt, err_cycle, err_cnt;
  int busy_fall, hold_viol, valid_cnt, overlap;
  bit timed_out;

  // Register contents: mode 0 random words, mode 1 element value = flat index.
  task automatic fill_reg(input int a, input int m, input int n, input int mode);
    for (int k = 0; k < M * N; k++)
      rf_data[a][k*FP +: FP] = (mode == 1) ? FP'(k) : $urandom;
    rf_m[a] = (MBITS + 1)'(m);
    rf_n[a] = (NBITS + 1)'(n);
  endtask

  function automatic void build_expected(input logic [FP*M*N-1:0] data, input int m, input int n);
    exp_q.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        exp_q.push_back(data[(i*N+j)*FP +: FP]);
  endfunction

  // The k-th accepted element is the k-th ready-high cycle from cycle 2 on.
  function automatic int model_ack(input int count);
    int k = 0;
    for (int c = 2; c < 300; c++) begin
      if (ready_log[c]) k++;
      if (k == count) return c + 1;
    end
    return -1;
  endfunction

  // ready modes: 0 high, 1 random, 2 toggling, 3 low within [st_lo, st_hi].
  task automatic run_store(input int addr, input int mode, input int st_lo, input int st_hi,
                           input bit poke);
    logic [FP-1:0] prev_el;
    bit prev_stall = 1'b0;
    bit seen_busy  = 1'b0;
    obs_q.delete();
    first_valid = -1; ack_cycle = -1; ack_cnt = 0; err_cycle = -1; err_cnt = 0;
    busy_fall = -1; hold_viol = 0; valid_cnt = 0; overlap = 0; timed_out = 1'b1;
    prev_el = '0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      en         = (c == 0) || (poke && (c == 3 || c == 4));
      store_addr = (c == 0) ? MATRIX_REG_SIZE'(addr) : MATRIX_REG_SIZE'($urandom_range(0, 7));
      if (poke && c == 3) fill_reg(addr, 1, 1, 0);
      case (mode)
        0:       ready = 1'b1;
        1:       ready = 1'($urandom_range(0, 1));
        2:       ready = (c % 2 == 1);
        default: ready = !(c >= st_lo && c <= st_hi);
      endcase
      ready_log[c] = ready;
      @(negedge clk);
      if (prev_stall && (!valid || element_out !== prev_el)) hold_viol++;
      prev_stall = valid && !ready;
      prev_el    = element_out;
      if (valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = c;
        if (ready) obs_q.push_back(element_out);
      end
      if (ack) begin ack_cnt++; if (ack_cycle < 0) ack_cycle = c; end
      if (error) begin err_cnt++; if (err_cycle < 0) err_cycle = c; end
      if (ack && error) overlap++;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) begin
        busy_fall = c;
        timed_out = 1'b0;
        break;
      end
    end
    en    = 1'b0;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; ready = 1'b0; store_addr = '0;
    for (int a = 0; a < 8; a++) fill_reg(a, 1, 1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_cnt++; if (valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b expected 0", valid); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %0b expected 0", busy); else pass_cnt++;
    check_cnt++; if (ack !== 1'b0 || error !== 1'b0) $display("[TB] FAIL reset_ack_err got %0b%0b expected 00", ack, error); else pass_cnt++;
    check_cnt++; if (element_out !== '0) $display("[TB] FAIL reset_element got %h expected 0", element_out); else pass_cnt++;
    check_cnt++; if (matrix_m_size !== '0 || matrix_n_size !== '0) $display("[TB] FAIL reset_sizes got %0d,%0d expected 0,0", matrix_m_size, matrix_n_size); else pass_cnt++;
    check_cnt++; if (reg_store_addr !== '0) $display("[TB] FAIL reset_addr got %0d expected 0", reg_store_addr); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic_2x2();
    logic [FP-1:0] vals [4];
    vals[0] = 32'h3f800000; vals[1] = 32'h424951ec; vals[2] = 32'hc0200000; vals[3] = 32'h3e000000;
    fill_reg(0, 2, 2, 0);
    rf_data[0][0*FP +: FP] = vals[0];
    rf_data[0][1*FP +: FP] = vals[1];
    rf_data[0][4*FP +: FP] = vals[2];
    rf_data[0][5*FP +: FP] = vals[3];
    run_store(0, 0, 0, 0, 1'b0);
    check_cnt++; if (timed_out) $display("[TB] FAIL basic_timeout got busy_fall %0d expected 7", busy_fall); else pass_cnt++;
    check_cnt++; if (obs_q.size() != 4) $display("[TB] FAIL basic_count got %0d expected 4", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== vals[i]) $display("[TB] FAIL basic_elem%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, vals[i]);
      else pass_cnt++;
    end
    check_cnt++; if (first_valid != 2) $display("[TB] FAIL basic_first_valid got %0d expected 2", first_valid); else pass_cnt++;
    check_cnt++; if (ack_cycle != 6 || ack_cnt != 1) $display("[TB] FAIL basic_ack got cycle %0d count %0d expected 6/1", ack_cycle, ack_cnt); else pass_cnt++;
    check_cnt++; if (busy_fall != 7) $display("[TB] FAIL basic_busy_fall got %0d expected 7", busy_fall); else pass_cnt++;
    check_cnt++; if (err_cnt != 0) $display("[TB] FAIL basic_error got %0d expected 0", err_cnt); else pass_cnt++;
    check_cnt++; if (matrix_m_size !== 3'd2 || matrix_n_size !== 3'd2) $display("[TB] FAIL basic_sizes got %0d,%0d expected 2,2", matrix_m_size, matrix_n_size); else pass_cnt++;
  endtask

  task automatic test_stall();
    build_expected(rf_data[0], 2, 2);
    run_store(0, 3, 3, 5, 1'b0);
    check_cnt++; if (timed_out) $display("[TB] FAIL stall_timeout got busy_fall %0d expected 10", busy_fall); else pass_cnt++;
    check_cnt++; if (obs_q.size() != 4) $display("[TB] FAIL stall_count got %0d expected 4", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("[TB] FAIL stall_elem%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      else pass_cnt++;
    end
    check_cnt++; if (hold_viol != 0) $display("[TB] FAIL stall_hold got %0d violations expected 0", hold_viol); else pass_cnt++;
    check_cnt++; if (ack_cycle != 9) $display("[TB] FAIL stall_ack got %0d expected 9", ack_cycle); else pass_cnt++;
    check_cnt++; if (valid_cnt != 7) $display("[TB] FAIL stall_valid_cycles got %0d expected 7", valid_cnt); else pass_cnt++;
  endtask

  task automatic test_error();
    int ms [3];
    int ns [3];
    ms[0] = 0; ns[0] = 2;
    ms[1] = 5; ns[1] = 1;
    ms[2] = 2; ns[2] = 5;
    for (int t = 0; t < 3; t++) begin
      fill_reg(2, ms[t], ns[t], 0);
      run_store(2, 0, 0, 0, 1'b0);
      check_cnt++; if (err_cycle != 2 || err_cnt != 1) $display("[TB] FAIL error%0d_pulse got cycle %0d count %0d expected 2/1", t, err_cycle, err_cnt); else pass_cnt++;
      check_cnt++; if (valid_cnt != 0 || ack_cnt != 0) $display("[TB] FAIL error%0d_quiet got valid %0d ack %0d expected 0/0", t, valid_cnt, ack_cnt); else pass_cnt++;
      check_cnt++; if (busy_fall != 3) $display("[TB] FAIL error%0d_busy_fall got %0d expected 3", t, busy_fall); else pass_cnt++;
      check_cnt++; if (matrix_m_size !== 3'(ms[t]) || matrix_n_size !== 3'(ns[t])) $display("[TB] FAIL error%0d_sizes got %0d,%0d expected %0d,%0d", t, matrix_m_size, matrix_n_size, ms[t], ns[t]); else pass_cnt++;
    end
  endtask

  task automatic test_full_toggle();
    int exp_ack;
    fill_reg(1, 4, 4, 1);
    build_expected(rf_data[1], 4, 4);
    run_store(1, 2, 0, 0, 1'b0);
    exp_ack = model_ack(16);
    check_cnt++; if (obs_q.size() != 16) $display("[TB] FAIL full_count got %0d expected 16", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("[TB] FAIL full_elem%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      else pass_cnt++;
    end
    check_cnt++; if (ack_cycle != exp_ack || ack_cnt != 1) $display("[TB] FAIL full_ack got %0d expected %0d", ack_cycle, exp_ack); else pass_cnt++;
    check_cnt++; if (hold_viol != 0) $display("[TB] FAIL full_hold got %0d violations expected 0", hold_viol); else pass_cnt++;
  endtask

  task automatic test_overwrite();
    fill_reg(3, 2, 2, 0);
    build_expected(rf_data[3], 2, 2);
    run_store(3, 0, 0, 0, 1'b1);
    check_cnt++; if (obs_q.size() != 4) $display("[TB] FAIL overwrite_count got %0d expected 4", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("[TB] FAIL overwrite_elem%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      else pass_cnt++;
    end
    check_cnt++; if (ack_cnt != 1 || ack_cycle != 6) $display("[TB] FAIL overwrite_ack got cycle %0d count %0d expected 6/1", ack_cycle, ack_cnt); else pass_cnt++;
    check_cnt++; if (busy_fall != 7) $display("[TB] FAIL overwrite_busy_fall got %0d expected 7", busy_fall); else pass_cnt++;
  endtask

  task automatic test_random();
    int m, n, a, exp_ack;
    for (int t = 0; t < 6; t++) begin
      m = $urandom_range(1, M);
      n = $urandom_range(1, N);
      a = $urandom_range(0, 7);
      fill_reg(a, m, n, 0);
      build_expected(rf_data[a], m, n);
      run_store(a, 1, 0, 0, 1'b0);
      exp_ack = model_ack(m * n);
      check_cnt++; if (obs_q.size() != m * n) $display("[TB] FAIL rand%0d_count got %0d expected %0d", t, obs_q.size(), m * n); else pass_cnt++;
      for (int i = 0; i < exp_q.size(); i++) begin
        check_cnt++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("[TB] FAIL rand%0d_elem%0d got %h expected %h", t, i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
        else pass_cnt++;
      end
      check_cnt++; if (ack_cycle != exp_ack || ack_cnt != 1 || overlap != 0) $display("[TB] FAIL rand%0d_ack got %0d expected %0d", t, ack_cycle, exp_ack); else pass_cnt++;
      check_cnt++; if (hold_viol != 0) $display("[TB] FAIL rand%0d_hold got %0d violations expected 0", t, hold_viol); else pass_cnt++;
      check_cnt++; if (matrix_m_size !== 3'(m) || matrix_n_size !== 3'(n)) $display("[TB] FAIL rand%0d_sizes got %0d,%0d expected %0d,%0d", t, matrix_m_size, matrix_n_size, m, n); else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    fill_reg(5, 4, 4, 0);
    build_expected(rf_data[5], 4, 4);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      en = (c == 0); store_addr = 3'd5; ready = 1'b1;
    end
    rst = 1'b1;
    #1;
    check_cnt++; if (valid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL midrst_valid_busy got %0b%0b expected 00", valid, busy); else pass_cnt++;
    check_cnt++; if (element_out !== '0 || ack !== 1'b0 || error !== 1'b0) $display("[TB] FAIL midrst_outputs got %h %0b%0b expected 0 00", element_out, ack, error); else pass_cnt++;
    check_cnt++; if (matrix_m_size !== '0 || matrix_n_size !== '0 || reg_store_addr !== '0) $display("[TB] FAIL midrst_regs got %0d,%0d,%0d expected 0,0,0", matrix_m_size, matrix_n_size, reg_store_addr); else pass_cnt++;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_store(5, 0, 0, 0, 1'b0);
    check_cnt++; if (obs_q.size() != 16) $display("[TB] FAIL midrst_count got %0d expected 16", obs_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size(); i++) begin
      check_cnt++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) $display("[TB] FAIL midrst_elem%0d got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      else pass_cnt++;
    end
    check_cnt++; if (first_valid != 2 || ack_cycle != 18) $display("[TB] FAIL midrst_timing got valid %0d ack %0d expected 2/18", first_valid, ack_cycle); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_2x2();
    test_stall();
    test_error();
    test_full_toggle();
    test_overwrite();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
